// File: rtl/sysx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysx_pkg
// Brief    : Shared constants and helpers for the sysX v1 slave port.
// Revision : 1.0 - initial release
// ============================================================================
package sysx_pkg;

    localparam logic [1:0] SYSX_REG_RX     = 2'd0;
    localparam logic [1:0] SYSX_REG_TX     = 2'd1;
    localparam logic [1:0] SYSX_REG_STATUS = 2'd2;
    localparam logic [1:0] SYSX_REG_CONFIG = 2'd3;

    localparam logic [2:0] EDGE_LOAD = 3'd1;
    localparam logic [2:0] EDGE_LOLO = 3'd2;
    localparam logic [2:0] EDGE_HIHI = 3'd5;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_COUNT_LO = 1;
    localparam int STAT_TXVALID  = 4;
    localparam int STAT_OVERFLOW = 5;

    function automatic logic [2:0] satCount3(input int unsigned cnt);
        return (cnt > 32'd7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysx_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sysx_slave_fifo
// Brief    : Show-ahead synchronous FIFO; a pop frees room for a same-cycle push.
// Revision : 1.0 - initial release
// ============================================================================
module sysx_slave_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  iClkA,
    input  logic                  iReset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int                    DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   C_DEPTH   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_doPush;
    logic                  w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == C_DEPTH);
    assign o_head   = r_mem[r_rdPtr];
    assign o_count  = r_count;
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge iClkA) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge iClkA) begin
        if (iReset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + C_PTR_ONE;
            if (w_doPop)  r_rdPtr <= r_rdPtr + C_PTR_ONE;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysx_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : sysx_slave_port
// Brief    : sysX v1 slave endpoint: oversampled bus framing, RX FIFO, TX shadow.
// Revision : 1.0 - initial release
// ============================================================================
module sysx_slave_port
    import sysx_pkg::*;
#(
    parameter logic [1:0] pSlaveId       = 2'd1,
    parameter int         pRxDepthLog2   = 2,
    parameter int         pIdleCycles    = 16,
    parameter logic [7:0] pIdleFill      = 8'hFF,
    parameter bit         pDropIdleWords = 1'b1
) (
    input  logic        iClkA,
    input  logic        iReset,
    input  logic        iBusClock,
    input  logic [1:0]  iBusSelect,
    input  logic [7:0]  iBusMOSI,
    output logic [7:0]  oBusMISO,
    output logic        oBusMISOEnable,
    output logic        oBusInterrupt,
    input  logic [1:0]  iAddress,
    input  logic        iWrite,
    input  logic        iRead,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    output logic        oHostInterrupt
);

    localparam int                IDLE_W   = $clog2(pIdleCycles + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(pIdleCycles);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

    logic [1:0]          r_clkSync;
    logic                r_clkPrev;
    logic [1:0]          r_selMeta;
    logic [1:0]          r_selSync;
    logic [2:0]          r_edge;
    logic [IDLE_W-1:0]   r_idleCnt;
    logic [31:0]         r_shadow;
    logic [31:0]         r_rxWord;
    logic [7:0]          r_miso;
    logic                r_pushReq;
    logic [31:0]         r_txReg;
    logic                r_txValid;
    logic                r_overflow;
    logic                r_intEnable;
    logic [31:0]         r_data;

    logic                w_busClk;
    logic                w_fall;
    logic                w_selected;
    logic                w_shadowLoad;
    logic [31:0]         w_loadWord;
    logic [1:0]          w_byteIdx;
    logic [1:0]          w_nextIdx;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_head;
    logic                w_full;
    logic                w_empty;
    logic [pRxDepthLog2:0] w_count;
    logic [31:0]         w_status;

    assign w_busClk     = r_clkSync[1];
    assign w_fall       = r_clkPrev & ~w_busClk;
    assign w_selected   = (r_selSync == pSlaveId);
    assign w_shadowLoad = w_selected & w_fall & (r_edge == 3'd0);
    assign w_loadWord   = r_txValid ? r_txReg : {4{pIdleFill}};
    assign w_byteIdx    = 2'(r_edge + 3'd1 - EDGE_LOLO);
    assign w_nextIdx    = w_byteIdx + 2'd1;
    assign w_push       = r_pushReq & ~(pDropIdleWords && (r_rxWord == 32'hFFFF_FFFF));
    assign w_pop        = iRead & (iAddress == SYSX_REG_RX) & ~w_empty;

    assign oBusMISO       = r_miso;
    assign oBusMISOEnable = w_selected;
    assign oBusInterrupt  = r_intEnable & r_txValid;
    assign oData          = r_data;
    assign oHostInterrupt = ~w_empty;

    always_ff @(posedge iClkA) begin
        if (iReset) begin
            r_clkSync <= 2'b11;
            r_clkPrev <= 1'b1;
            r_selMeta <= 2'd0;
            r_selSync <= 2'd0;
        end else begin
            r_clkSync <= {r_clkSync[0], iBusClock};
            r_clkPrev <= w_busClk;
            r_selMeta <= iBusSelect;
            r_selSync <= r_selMeta;
        end
    end

    // Frame sequencing: fall wins over the idle timeout since the count is stale by one cycle.
    always_ff @(posedge iClkA) begin
        if (iReset) begin
            r_edge    <= 3'd0;
            r_idleCnt <= '0;
            r_shadow  <= {4{pIdleFill}};
            r_rxWord  <= '0;
            r_miso    <= pIdleFill;
            r_pushReq <= 1'b0;
        end else begin
            r_pushReq <= 1'b0;
            if (!w_busClk) begin
                r_idleCnt <= '0;
            end else if (r_idleCnt != IDLE_MAX) begin
                r_idleCnt <= r_idleCnt + IDLE_ONE;
            end

            if (!w_selected) begin
                r_edge <= 3'd0;
                r_miso <= pIdleFill;
            end else if (w_fall) begin
                if (r_edge != 3'd7) r_edge <= r_edge + 3'd1;
                if (r_edge == 3'd0) begin
                    r_shadow <= w_loadWord;
                    r_miso   <= w_loadWord[7:0];
                end else if (r_edge >= EDGE_LOAD && r_edge < EDGE_HIHI) begin
                    r_rxWord[{w_byteIdx, 3'b000} +: 8] <= iBusMOSI;
                    if (r_edge == EDGE_HIHI - 3'd1) begin
                        r_miso    <= pIdleFill;
                        r_pushReq <= 1'b1;
                    end else begin
                        r_miso <= r_shadow[{w_nextIdx, 3'b000} +: 8];
                    end
                end
            end else if (r_idleCnt == IDLE_MAX) begin
                r_edge <= 3'd0;
                r_miso <= pIdleFill;
            end
        end
    end

    always_comb begin
        w_status                       = '0;
        w_status[STAT_EMPTY]           = w_empty;
        w_status[STAT_COUNT_LO +: 3]   = satCount3(32'(w_count));
        w_status[STAT_TXVALID]         = r_txValid;
        w_status[STAT_OVERFLOW]        = r_overflow;
    end

    // A TX write coinciding with the shadow load stays pending: the set below wins.
    always_ff @(posedge iClkA) begin
        if (iReset) begin
            r_txReg     <= '0;
            r_txValid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_intEnable <= 1'b0;
            r_data      <= '0;
        end else begin
            if (w_shadowLoad) r_txValid <= 1'b0;
            if (iWrite) begin
                case (iAddress)
                    SYSX_REG_TX: begin
                        r_txReg   <= iData;
                        r_txValid <= 1'b1;
                    end
                    SYSX_REG_STATUS: if (iData[STAT_OVERFLOW]) r_overflow <= 1'b0;
                    SYSX_REG_CONFIG: r_intEnable <= iData[0];
                    default: ;
                endcase
            end
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (iRead) begin
                case (iAddress)
                    SYSX_REG_RX:     r_data <= w_empty ? 32'd0 : w_head;
                    SYSX_REG_TX:     r_data <= r_txReg;
                    SYSX_REG_STATUS: r_data <= w_status;
                    default:         r_data <= {31'd0, r_intEnable};
                endcase
            end
        end
    end

    sysx_slave_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (pRxDepthLog2)
    ) u_rxFifo (
        .iClkA   (iClkA),
        .iReset  (iReset),
        .i_push  (w_push),
        .i_data  (r_rxWord),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: doc/sysx_slave_port.md
Name: sysx_slave_port

Overview:
- Peripheral-side endpoint of the sysX v1 serial bus, directly downstream of the sysX master controller.
- Oversamples the master's bus clock, 8-bit MOSI and 2-bit select in the local iClkA domain.
- Assembles each 4-byte frame (LoLo, Lo, Hi, HiHi) into a 32-bit word and pushes it into an RX FIFO for the local host.
- Shifts a host-loaded 32-bit TX word back on MISO in the same frame (full duplex).

Parameters:
pSlaveId, 2'd1, select code this port answers to (iBusSelect == pSlaveId)
pRxDepthLog2, 2, RX FIFO depth = 2**pRxDepthLog2 words
pIdleCycles, 16, consecutive iClkA cycles of synced bus clock high that end/reset a frame
pIdleFill, 8'hFF, MISO byte value when no TX word is loaded
pDropIdleWords, 1, 1 = a received word of 32'hFFFFFFFF (master receive-only frame) is not pushed

Ports:
iClkA  in  1  local clock; must run at least 8x the bus clock rate
iReset  in  1  synchronous, active-high reset
iBusClock  in  1  sysX bus clock from master; idles high
iBusSelect  in  2  sysX chip select from master
iBusMOSI  in  8  master-to-slave byte
oBusMISO  out  8  slave-to-master byte
oBusMISOEnable  out  1  high when selected; drives the external tristate
oBusInterrupt  out  1  request to master: rIntEnable & txValid
iAddress  in  2  host register address
iWrite  in  1  host write strobe, one cycle
iRead  in  1  host read strobe, one cycle
iData  in  32  host write data
oData  out  32  host read data, registered
oHostInterrupt  out  1  high while RX FIFO not empty

Behaviour:
- Interface: reset iReset, synchronous, active-high; clock iClkA.
- Reset values: oBusMISO = pIdleFill; oBusMISOEnable = 0; oBusInterrupt = 0; oData = 0; oHostInterrupt = 0. FIFO is emptied and all flags are cleared.
- Synchronisers:
  - iBusClock and iBusSelect each pass through 2 flops.
  - Falling edge (fall) and rising edge are detected on the synced clock.
  - iBusMOSI is captured on the cycle fall is detected; it is stable for a half period.
- Frame counter rEdge (0..7), advanced on each fall while selected. States:
  - IDLE: rEdge = 0. Load tx shadow = TX register if txValid, else {4{pIdleFill}}; clear txValid when loaded. oBusMISO = shadow[7:0].
  - First fall (master Load phase): rEdge -> 1. No capture.
  - Falls 2..5 (master LoLo, Lo, Hi, HiHi): capture MOSI into rx[7:0], [15:8], [23:16], [31:24] in that order.
  - After each capture, oBusMISO advances to the next shadow byte within 2 iClkA cycles, so the master samples it at its next fall.
  - After the HiHi capture: oBusMISO = pIdleFill. Push the word in the next cycle unless pDropIdleWords=1 and the word == 32'hFFFFFFFF.
  - Falls 6..7 (master Register, Store): counted, ignored. rEdge saturates at 7.
  - Idle counter: counts cycles with synced clock high; clears on any low. Reaching pIdleCycles returns the port to IDLE.
- Deselect mid-frame (synced select != pSlaveId): abort immediately to IDLE. No push. The partially sent TX word is lost and txValid stays cleared.
- oBusMISOEnable = synced select == pSlaveId.
- Host registers:
  - 0 RX: read returns the FIFO head and pops. Reading while empty returns 0 with no pop.
  - 1 TX: write loads the TX register and sets txValid. Writing while txValid is set overwrites; a frame already in progress uses the latched shadow.
  - 2 STATUS: read {26'h0, overflow, txValid, rxCount[2:0], rxEmpty}. rxCount saturates at 7 for deeper FIFOs. Writing 1 to bit 5 clears overflow.
  - 3 CONFIG: bit0 = rIntEnable. Read/write.
- oData is updated the cycle after iRead; 1-cycle latency.
- Push to a full FIFO: word dropped, overflow set (sticky).
- Push and pop in the same cycle: both occur, count unchanged, including when full.
- Host write to TX and IDLE shadow load in the same cycle: the shadow takes the old value and the new write stays pending with txValid=1.

Decomposition:
- Package sysx_pkg holds:
  - register address constants: SYSX_REG_RX = 0, TX = 1, STATUS = 2, CONFIG = 3;
  - frame edge constants: EDGE_LOAD = 1, EDGE_LOLO = 2, EDGE_HIHI = 5;
  - status bit indices.
- Sub-module sysx_slave_fifo: synchronous FIFO, parameterised width/depth, with push, pop, full, empty, count.

Test Plan:
- Select 1, master sends 32'h11223344, TX register preloaded with 32'hA5B6C7D8 -> RX head = 32'h11223344; master sees MISO bytes D8, C7, B6, A5; txValid = 0 after the frame.
- TX not loaded, frame with MOSI all 8'hFF -> MISO is FF x4; nothing pushed; rxEmpty stays 1.
- 5 frames sent with pRxDepthLog2=2 and no reads -> 4 words held, STATUS overflow = 1; writing STATUS 32'h20 clears overflow.
- Frame sent with iBusSelect = 2 -> oBusMISOEnable = 0, no push, TX register untouched.
- Select dropped after the Lo byte -> no push; the next full frame 32'hCAFEF00D is captured correctly.
- iReset asserted mid-frame after the Hi byte -> all outputs return to reset values; next frame 32'h00000001 is captured correctly.
